// File: rtl/switchbox_cfg_loader.sv
// Configuration loader for the 5/5/4/4-pin switch box: validates a framed stream of route words
// into a shadow buffer and commits a whole good frame to the active configuration in one edge.
module switchbox_cfg_loader #(
  parameter int unsigned     NTB  = 5,
  parameter int unsigned     NLR  = 4,
  parameter int unsigned     W    = 6,
  parameter logic [W-1:0]    SYNC = 6'h2A
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [W-1:0]                      in_data,
  input  logic                              in_last,
  input  logic                              cfg_clear,
  output logic [(2*NTB+2*NLR)*W-1:0]        cfg_active,
  output logic                              busy,
  output logic                              done,
  output logic                              err,
  output logic [2:0]                        err_code
);

  localparam int unsigned NS       = 2 * NTB + 2 * NLR;
  localparam logic [4:0]  LastSlot = 5'(NS - 1);

  localparam logic [2:0] ErrNone     = 3'd0;
  localparam logic [2:0] ErrHeader   = 3'd1;
  localparam logic [2:0] ErrSelect   = 3'd2;
  localparam logic [2:0] ErrRange    = 3'd3;
  localparam logic [2:0] ErrSelfLoop = 3'd4;
  localparam logic [2:0] ErrEarlyEnd = 3'd5;
  localparam logic [2:0] ErrNoLast   = 3'd6;
  localparam logic [2:0] ErrPreempt  = 3'd7;

  typedef enum logic [1:0] {StIdle, StLoad, StFlush, StCommit} state_e;

  state_e                 state;
  logic [4:0]             cnt;
  logic [NS-1:0][W-1:0]   shadow;
  logic                   beat;
  logic [2:0]             hdr_code;
  logic [2:0]             load_code;

  // Side codes: 1 top, 2 right, 3 bottom, 4 left. Slots run top, bottom, left, right.
  function automatic logic [2:0] word_check(input logic [4:0] slot, input logic [W-1:0] w);
    int unsigned s, idx, sel, own_side, own_idx;
    s   = 32'(slot);
    idx = 32'(w[W-1:3]);
    sel = 32'(w[2:0]);
    if (s < NTB) begin
      own_side = 1;
      own_idx  = s;
    end else if (s < 2 * NTB) begin
      own_side = 3;
      own_idx  = s - NTB;
    end else if (s < 2 * NTB + NLR) begin
      own_side = 4;
      own_idx  = s - 2 * NTB;
    end else begin
      own_side = 2;
      own_idx  = s - 2 * NTB - NLR;
    end
    if (sel == 0) return ErrNone;
    if (sel >= 5) return ErrSelect;
    if (((sel == 1 || sel == 3) && idx > NTB - 1) || ((sel == 2 || sel == 4) && idx > NLR - 1)) begin
      return ErrRange;
    end
    if (sel == own_side && idx == own_idx) return ErrSelfLoop;
    return ErrNone;
  endfunction

  assign in_ready = !rst && (state != StCommit);
  assign beat     = in_valid && in_ready;
  assign busy     = (state != StIdle);

  always_comb begin
    hdr_code = ErrNone;
    if (in_data != SYNC) begin
      hdr_code = ErrHeader;
    end else if (in_last) begin
      hdr_code = ErrEarlyEnd;
    end
  end

  // Route-rule violations outrank framing errors on the same beat.
  always_comb begin
    load_code = word_check(cnt, in_data);
    if (load_code == ErrNone) begin
      if (cnt != LastSlot && in_last) begin
        load_code = ErrEarlyEnd;
      end else if (cnt == LastSlot && !in_last) begin
        load_code = ErrNoLast;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= StIdle;
      cnt        <= '0;
      shadow     <= '0;
      cfg_active <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_code   <= ErrNone;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (cfg_clear) begin
        cfg_active <= '0;
      end
      unique case (state)
        StIdle: begin
          if (beat) begin
            if (hdr_code != ErrNone) begin
              err      <= 1'b1;
              err_code <= hdr_code;
              state    <= in_last ? StIdle : StFlush;
            end else begin
              err_code <= ErrNone;
              cnt      <= '0;
              state    <= StLoad;
            end
          end
        end
        StLoad: begin
          if (beat) begin
            shadow[cnt] <= in_data;
            cnt         <= cnt + 5'd1;
            if (load_code != ErrNone) begin
              err      <= 1'b1;
              err_code <= load_code;
              state    <= in_last ? StIdle : StFlush;
            end else if (cnt == LastSlot) begin
              state <= StCommit;
            end
          end
        end
        StFlush: begin
          if (beat && in_last) begin
            state <= StIdle;
          end
        end
        StCommit: begin
          // A simultaneous clear wins over the commit and is reported as an error.
          if (cfg_clear) begin
            err      <= 1'b1;
            err_code <= ErrPreempt;
          end else begin
            cfg_active <= shadow;
            done       <= 1'b1;
          end
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_switchbox_cfg_loader.sv
// Directed, table-driven bench for switchbox_cfg_loader: each record is one frame with a single
// non-zero slot, plus hand-written reset sequences.
module tb_switchbox_cfg_loader;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [5:0]   in_data = 6'h00;
  logic         in_last = 1'b0;
  logic         cfg_clear = 1'b0;
  logic [107:0] cfg_active;
  logic         busy;
  logic         done;
  logic         err;
  logic [2:0]   err_code;

  int           vectors = 0;
  int           miscompares = 0;
  logic [107:0] exp_cfg = '0;

  typedef struct {
    logic [5:0] hdr;
    int         slot;
    logic [5:0] word;
    int         last_at;     // beat index carrying in_last (19 = one beat past the frame)
    int         clear_at;    // beat index with cfg_clear, -1 for none
    bit         clr_commit;  // raise cfg_clear in the COMMIT cycle
    bit         gap;         // random idle cycles between beats
    logic       exp_err;
    logic [2:0] exp_code;
    logic       exp_done;
  } vec_t;

  vec_t vecs[17];

  switchbox_cfg_loader dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .cfg_clear  (cfg_clear),
    .cfg_active (cfg_active),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .err_code   (err_code)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [107:0] act, input logic [107:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives one beat from a negedge, returns at the negedge after the accepting edge.
  task automatic send_beat(input logic [5:0] d, input logic l);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) begin
      vectors++;
      miscompares++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_frame(input int id, input vec_t v);
    logic [107:0] words;
    logic [5:0]   d;
    logic         got_err;
    logic [2:0]   got_code;
    logic         got_done;
    string        tag;
    int           nb;
    tag      = $sformatf("v%0d", id);
    words    = '0;
    words[v.slot*6 +: 6] = v.word;
    got_err  = 1'b0;
    got_code = 3'd0;
    nb       = v.last_at;
    for (int b = 0; b <= nb; b++) begin
      d = (b == 0) ? v.hdr : ((b <= 18) ? words[(b-1)*6 +: 6] : 6'h00);
      if (v.gap) repeat ($urandom_range(0, 2)) @(negedge clk);
      if (b == v.clear_at) cfg_clear = 1'b1;
      send_beat(d, b == v.last_at);
      if (b == v.clear_at) begin
        cfg_clear = 1'b0;
        check({tag, "_clear_midload"}, cfg_active, '0);
      end
      if (err && !got_err) begin
        got_err  = 1'b1;
        got_code = err_code;
      end
    end
    if (v.exp_done || v.clr_commit) check({tag, "_commit_ready"}, in_ready, 0);
    if (v.clr_commit) cfg_clear = 1'b1;
    @(negedge clk);
    cfg_clear = 1'b0;
    got_done  = done;
    if (err && !got_err) begin
      got_err  = 1'b1;
      got_code = err_code;
    end
    if (v.exp_done) exp_cfg = words;
    if (v.clr_commit) exp_cfg = '0;
    check({tag, "_err"}, got_err, v.exp_err);
    check({tag, "_code"}, got_code, v.exp_code);
    check({tag, "_done"}, got_done, v.exp_done);
    check({tag, "_cfg"}, cfg_active, exp_cfg);
    check({tag, "_busy"}, busy, 0);
    @(negedge clk);
    check({tag, "_code_held"}, err_code, v.exp_code);
    check({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    //          hdr    slot word   last clr cc gap err code done
    vecs[0]  = '{6'h2A, 0,  6'h0A, 18, -1, 0, 0, 0, 3'd0, 1};
    vecs[1]  = '{6'h2A, 0,  6'h0A, 18, -1, 0, 1, 0, 3'd0, 1};
    vecs[2]  = '{6'h2A, 5,  6'h06, 18, -1, 0, 0, 1, 3'd2, 0};
    vecs[3]  = '{6'h2A, 17, 6'h19, 18, -1, 0, 1, 0, 3'd0, 1};
    vecs[4]  = '{6'h2A, 10, 6'h22, 18, -1, 0, 0, 1, 3'd3, 0};
    vecs[5]  = '{6'h2A, 2,  6'h11, 18, -1, 0, 0, 1, 3'd4, 0};
    vecs[6]  = '{6'h15, 0,  6'h0A, 18, -1, 0, 0, 1, 3'd1, 0};
    vecs[7]  = '{6'h2A, 0,  6'h0A, 7,  -1, 0, 0, 1, 3'd5, 0};
    vecs[8]  = '{6'h2A, 0,  6'h0A, 19, -1, 0, 0, 1, 3'd6, 0};
    vecs[9]  = '{6'h2A, 4,  6'h38, 18, -1, 0, 0, 0, 3'd0, 1};
    vecs[10] = '{6'h2A, 0,  6'h2B, 18, -1, 0, 0, 1, 3'd3, 0};
    vecs[11] = '{6'h2A, 9,  6'h23, 18, -1, 0, 0, 1, 3'd4, 0};
    vecs[12] = '{6'h2A, 13, 6'h1C, 18, -1, 0, 0, 1, 3'd4, 0};
    vecs[13] = '{6'h2A, 13, 6'h1A, 18, -1, 0, 0, 0, 3'd0, 1};
    vecs[14] = '{6'h2A, 0,  6'h0A, 18, 5,  0, 0, 0, 3'd0, 1};
    vecs[15] = '{6'h2A, 3,  6'h0A, 18, -1, 1, 0, 1, 3'd7, 0};
    vecs[16] = '{6'h2A, 6,  6'h0A, 18, -1, 0, 1, 0, 3'd0, 1};

    // Reset state, including in_ready held low by rst.
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_cfg", cfg_active, '0);
    check("rst_flags", {busy, done, err, err_code}, '0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);

    for (int i = 0; i < 17; i++) run_frame(i, vecs[i]);

    // A rejected header leaves a sticky code and a live configuration for rst to wipe.
    run_frame(17, vecs[6]);
    send_beat(6'h2A, 1'b0);
    for (int b = 1; b <= 8; b++) send_beat(6'h00, 1'b0);
    in_valid = 1'b1;
    in_data  = 6'h11;
    rst      = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_cfg", cfg_active, '0);
    check("midrst_flags", {busy, done, err, err_code}, '0);
    rst      = 1'b0;
    in_valid = 1'b0;
    exp_cfg  = '0;
    @(negedge clk);
    run_frame(18, vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
